complex_div_seq: RTL
====================

COMPLEX_DIV_SEQ -- requirements
Module: complex_div_seq

Interface
REQ-001 Parameter IN_W, default 4: width of each signed two's-complement operand.
REQ-002 Parameter FRAC_W, default 4: fractional bits of each quotient; quotient width OUT_W = IN_W+FRAC_W.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  operands valid.
REQ-006 in_ready  output  1  block idle; accepts operands.
REQ-007 A_in, B_in  input  IN_W each  dividend real, imaginary (signed).
REQ-008 C_in, D_in  input  IN_W each  divisor real, imaginary (signed).
REQ-009 out_valid  output  1  results valid.
REQ-010 out_ready  input  1  consumer takes results.
REQ-011 Div_r, Div_i  output  OUT_W each  quotient real, imaginary, signed fixed-point with FRAC_W fractional bits (Q4.4 at defaults).
REQ-012 div_zero  output  1  divisor was 0+j0.
REQ-013 sat  output  1  at least one quotient component saturated.

Function
REQ-014 Compute (A+jB)/(C+jD): Nr = A*C+B*D, Ni = B*C-A*D, Den = C*C+D*D; Div_r = Nr/Den, Div_i = Ni/Den, each scaled by 2^FRAC_W.
REQ-015 Nr and Ni are computed at 2*IN_W+1 bits signed, Den at 2*IN_W+1 bits unsigned; no intermediate overflow.
REQ-016 Division is unsigned restoring on magnitudes |N|<<FRAC_W, 2*IN_W+FRAC_W iterations (12 at defaults), one quotient bit per cycle, real and imaginary in parallel; sign applied afterwards; default truncates toward zero.
REQ-017 States: IDLE, CALC, DIV, DONE.
REQ-018 IDLE: in_ready=1; on in_valid, capture A_in..D_in, go to CALC.
REQ-019 CALC: register Nr, Ni, Den, signs; load iteration counter; if Den==0 go to DONE with div_zero=1, Div_r=Div_i=0, sat=0; else go to DIV.
REQ-020 DIV: one iteration per cycle; after the last iteration, apply sign and saturation; go to DONE.
REQ-021 DONE: out_valid=1, outputs stable; on out_ready go to IDLE; out_valid held indefinitely without out_ready.
REQ-022 Latency: out_valid rises exactly 2*IN_W+FRAC_W+2 cycles (14 at defaults) after the accepting edge; 2 cycles for divide-by-zero.
REQ-023 Saturation: result above 2^(OUT_W-1)-1 gives 0x7F, below -2^(OUT_W-1) gives 0x80 (defaults); sat=1; exactly -2^(OUT_W-1) is not saturation.
REQ-024 in_valid outside IDLE is ignored (in_ready=0); operand changes after capture have no effect.
REQ-025 No acceptance in the same cycle as the output handshake; IDLE is always visited for at least one cycle.

Reset
REQ-026 rst_n low asynchronously forces IDLE; in_ready=1 after release, out_valid=0, Div_r=Div_i=0, div_zero=0, sat=0; all internal registers cleared.
REQ-027 Reset during CALC/DIV/DONE abandons the operation; no out_valid for it.

Configuration
REQ-028 Macro COMPLEX_DIV_ROUND_EN defined: one extra quotient bit computed; round half away from zero; latency +1 cycle (15 at defaults); saturation applied after rounding.
REQ-029 Macro undefined: truncation toward zero per REQ-016; latency per REQ-022.

Structure
REQ-030 Package complex_div_pkg holds the state enum, default widths and the derived constants (iteration count, latency).
REQ-031 One sub-module, cdiv_udiv: an unsigned restoring-divider datapath (one iteration per enable), instantiated twice (real, imaginary) and controlled by the top FSM.

Verification
REQ-032 A=2,B=0,C=1,D=0 -> Div_r=0x20, Div_i=0x00, sat=0, div_zero=0, out_valid 14 cycles after accept.
REQ-033 A=0,B=1,C=1,D=1 -> Div_r=0x08, Div_i=0x08 (0.5+j0.5).
REQ-034 A=2,B=0,C=3,D=0 -> Div_r=0x0A truncated / 0x0B with COMPLEX_DIV_ROUND_EN; A=4'hE same divisor -> 0xF6 / 0xF5.
REQ-035 A=4'h8,B=0,C=4'hF,D=0 -> Div_r=0x7F, sat=1; A=4'h8,C=1 -> Div_r=0x80, sat=0.
REQ-036 C=D=0 -> div_zero=1, outputs 0x00, out_valid 2 cycles after accept; out_ready held low 5 cycles -> outputs stable, in_valid ignored.
REQ-037 rst_n pulsed low mid-DIV -> outputs cleared immediately; no out_valid; next operation correct.

Source files
------------

// File: rtl/complex_div_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | complex_div_pkg                                                        |
// | Shared state encoding, default widths and derived timing constants for |
// | the sequential complex divider. Honours macro COMPLEX_DIV_ROUND_EN.    |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
package complex_div_pkg;

    localparam int DEF_IN_W   = 4;
    localparam int DEF_FRAC_W = 4;

`ifdef COMPLEX_DIV_ROUND_EN
    localparam int ROUND_BITS = 1;
`else
    localparam int ROUND_BITS = 0;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    function automatic int iter_count(input int in_w, input int frac_w);
        return 2 * in_w + frac_w + ROUND_BITS;
    endfunction

    // Two CALC cycles precede the divider iterations.
    function automatic int latency(input int in_w, input int frac_w);
        return iter_count(in_w, frac_w) + 2;
    endfunction

    localparam int DEF_ITER    = iter_count(DEF_IN_W, DEF_FRAC_W);
    localparam int DEF_LATENCY = latency(DEF_IN_W, DEF_FRAC_W);

endpackage
`default_nettype wire

// File: rtl/cdiv_udiv.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | cdiv_udiv                                                              |
// | Unsigned restoring divider datapath, one quotient bit per enable.      |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module cdiv_udiv
    import complex_div_pkg::*;
#(
    parameter int NB    = DEF_ITER,
    parameter int DEN_W = 2 * DEF_IN_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_en,
    input  logic [NB-1:0]    i_dividend,
    input  logic [DEN_W-1:0] i_divisor,
    output logic [NB-1:0]    o_quot_next
);

    logic [NB-1:0]    r_dvd;
    logic [NB-2:0]    r_quot;
    logic [DEN_W-1:0] r_rem;
    logic [DEN_W-1:0] r_div;

    logic [DEN_W:0]   w_trial;
    logic [DEN_W-1:0] w_diff;
    logic             w_ge;

    // Remainder stays below the divisor, so the difference fits DEN_W bits.
    assign w_trial     = {r_rem, r_dvd[NB-1]};
    assign w_ge        = (w_trial >= {1'b0, r_div});
    assign w_diff      = w_trial[DEN_W-1:0] - r_div;
    assign o_quot_next = {r_quot, w_ge};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dvd  <= '0;
            r_quot <= '0;
            r_rem  <= '0;
            r_div  <= '0;
        end else if (i_load) begin
            r_dvd  <= i_dividend;
            r_quot <= '0;
            r_rem  <= '0;
            r_div  <= i_divisor;
        end else if (i_en) begin
            r_dvd  <= r_dvd << 1;
            r_quot <= o_quot_next[NB-2:0];
            r_rem  <= w_ge ? w_diff : w_trial[DEN_W-1:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/complex_div_seq.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | complex_div_seq                                                        |
// | Sequential fixed-point complex divider (A+jB)/(C+jD) with saturation.  |
// | Macro COMPLEX_DIV_ROUND_EN selects round-half-away-from-zero.          |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module complex_div_seq
    import complex_div_pkg::*;
#(
    parameter int IN_W   = DEF_IN_W,
    parameter int FRAC_W = DEF_FRAC_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [IN_W-1:0]   A_in,
    input  logic signed [IN_W-1:0]   B_in,
    input  logic signed [IN_W-1:0]   C_in,
    input  logic signed [IN_W-1:0]   D_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [IN_W+FRAC_W-1:0]   Div_r,
    output logic [IN_W+FRAC_W-1:0]   Div_i,
    output logic                     div_zero,
    output logic                     sat
);

    localparam int c_OUT_W  = IN_W + FRAC_W;
    localparam int c_PROD_W = 2 * IN_W + 1;
    localparam int c_MAG_W  = 2 * IN_W;
    localparam int c_NB     = iter_count(IN_W, FRAC_W);
    localparam int c_SHIFT  = FRAC_W + ROUND_BITS;
    localparam int c_CNT_W  = $clog2(c_NB + 1);

    localparam logic [c_NB:0]      c_POS_LIM  = (c_NB+1)'((64'd1 << (c_OUT_W - 1)) - 64'd1);
    localparam logic [c_NB:0]      c_NEG_LIM  = (c_NB+1)'(64'd1 << (c_OUT_W - 1));
    localparam logic [c_OUT_W-1:0] c_MAX_CODE = {1'b0, {(c_OUT_W-1){1'b1}}};
    localparam logic [c_OUT_W-1:0] c_MIN_CODE = {1'b1, {(c_OUT_W-1){1'b0}}};

    state_t r_state, w_state_next;
    logic   w_capture, w_load, w_en, w_finish;

    logic                       r_phase;
    logic signed [IN_W-1:0]     r_a, r_b, r_c, r_d;
    logic signed [c_PROD_W-1:0] r_nr, r_ni;
    logic [c_PROD_W-1:0]        r_den;
    logic [c_CNT_W-1:0]         r_cnt;
    logic [c_OUT_W-1:0]         r_div_r, r_div_i;
    logic                       r_dz, r_sat;

    logic signed [c_PROD_W-1:0] w_ax, w_bx, w_cx, w_dx;
    logic signed [c_PROD_W-1:0] w_nr, w_ni, w_den;
    logic                       w_neg_r, w_neg_i;
    logic [c_MAG_W-1:0]         w_mag_r, w_mag_i;
    logic [c_NB-1:0]            w_q_r, w_q_i;
    logic [c_NB:0]              w_rq_r, w_rq_i;
    logic [c_OUT_W:0]           w_fin_r, w_fin_i;

    assign w_ax = {{(c_PROD_W-IN_W){r_a[IN_W-1]}}, r_a};
    assign w_bx = {{(c_PROD_W-IN_W){r_b[IN_W-1]}}, r_b};
    assign w_cx = {{(c_PROD_W-IN_W){r_c[IN_W-1]}}, r_c};
    assign w_dx = {{(c_PROD_W-IN_W){r_d[IN_W-1]}}, r_d};

    assign w_nr  = w_ax * w_cx + w_bx * w_dx;
    assign w_ni  = w_bx * w_cx - w_ax * w_dx;
    assign w_den = w_cx * w_cx + w_dx * w_dx;

    // |N| never exceeds 2^(2*IN_W-1), so the low c_MAG_W bits hold it exactly.
    assign w_neg_r = r_nr[c_PROD_W-1];
    assign w_neg_i = r_ni[c_PROD_W-1];
    assign w_mag_r = w_neg_r ? (c_MAG_W'(0) - r_nr[c_MAG_W-1:0]) : r_nr[c_MAG_W-1:0];
    assign w_mag_i = w_neg_i ? (c_MAG_W'(0) - r_ni[c_MAG_W-1:0]) : r_ni[c_MAG_W-1:0];

    cdiv_udiv #(.NB(c_NB), .DEN_W(c_PROD_W)) u_udiv_r (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_load      (w_load),
        .i_en        (w_en),
        .i_dividend  ({w_mag_r, {c_SHIFT{1'b0}}}),
        .i_divisor   (r_den),
        .o_quot_next (w_q_r)
    );

    cdiv_udiv #(.NB(c_NB), .DEN_W(c_PROD_W)) u_udiv_i (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_load      (w_load),
        .i_en        (w_en),
        .i_dividend  ({w_mag_i, {c_SHIFT{1'b0}}}),
        .i_divisor   (r_den),
        .o_quot_next (w_q_i)
    );

`ifdef COMPLEX_DIV_ROUND_EN
    // Extra LSB is the half bit; rounding the magnitude rounds away from zero.
    assign w_rq_r = ({1'b0, w_q_r} + (c_NB+1)'(1)) >> 1;
    assign w_rq_i = ({1'b0, w_q_i} + (c_NB+1)'(1)) >> 1;
`else
    assign w_rq_r = {1'b0, w_q_r};
    assign w_rq_i = {1'b0, w_q_i};
`endif

    function automatic logic [c_OUT_W:0] sat_apply(input logic [c_NB:0] mag, input logic neg);
        logic [c_OUT_W-1:0] low;
        low = mag[c_OUT_W-1:0];
        if (!neg && (mag > c_POS_LIM))
            return {1'b1, c_MAX_CODE};
        else if (neg && (mag > c_NEG_LIM))
            return {1'b1, c_MIN_CODE};
        else
            return {1'b0, neg ? (c_OUT_W'(0) - low) : low};
    endfunction

    assign w_fin_r = sat_apply(w_rq_r, w_neg_r);
    assign w_fin_i = sat_apply(w_rq_i, w_neg_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_load       = 1'b0;
        w_en         = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_capture    = 1'b1;
                    w_state_next = S_CALC;
                end
            end
            S_CALC: begin
                if (r_phase) begin
                    if (r_den == '0) begin
                        w_state_next = S_DONE;
                    end else begin
                        w_load       = 1'b1;
                        w_state_next = S_DIV;
                    end
                end
            end
            S_DIV: begin
                w_en = 1'b1;
                if (r_cnt == c_CNT_W'(1)) begin
                    w_finish     = 1'b1;
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready)
                    w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_c     <= '0;
            r_d     <= '0;
            r_nr    <= '0;
            r_ni    <= '0;
            r_den   <= '0;
            r_cnt   <= '0;
            r_div_r <= '0;
            r_div_i <= '0;
            r_dz    <= 1'b0;
            r_sat   <= 1'b0;
        end else begin
            if (w_capture) begin
                r_a     <= A_in;
                r_b     <= B_in;
                r_c     <= C_in;
                r_d     <= D_in;
                r_phase <= 1'b0;
            end
            if (r_state == S_CALC && !r_phase) begin
                r_nr    <= w_nr;
                r_ni    <= w_ni;
                r_den   <= w_den;
                r_phase <= 1'b1;
            end
            if (w_load)
                r_cnt <= c_CNT_W'(c_NB);
            else if (w_en)
                r_cnt <= r_cnt - c_CNT_W'(1);
            if (w_finish) begin
                r_div_r <= w_fin_r[c_OUT_W-1:0];
                r_div_i <= w_fin_i[c_OUT_W-1:0];
                r_sat   <= w_fin_r[c_OUT_W] | w_fin_i[c_OUT_W];
                r_dz    <= 1'b0;
            end
            if (r_state == S_CALC && r_phase && r_den == '0) begin
                r_div_r <= '0;
                r_div_i <= '0;
                r_sat   <= 1'b0;
                r_dz    <= 1'b1;
            end
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign Div_r     = r_div_r;
    assign Div_i     = r_div_i;
    assign div_zero  = r_dz;
    assign sat       = r_sat;

endmodule
`default_nettype wire
